// File: rtl/muxdc_config_sequencer.sv
// Multi-channel mux-dataflow config sequencer: walks every bus slot per channel, emitting
// descending window-column selects for the first k slots and padding the rest.
`timescale 1ns/1ps
module muxdc_config_sequencer #(
  parameter int unsigned BUS_W     = 16,
  parameter int unsigned KSIZE_MAX = 5,
  parameter int unsigned NUM_CH    = 3,
  localparam int unsigned BW  = $clog2(BUS_W),
  localparam int unsigned KW  = $clog2(KSIZE_MAX + 1),
  localparam int unsigned CHW = $clog2(NUM_CH + 1)
) (
  input  logic           MUXDC_STATEMACHINE_Clk,
  input  logic           MUXDC_STATEMACHINE_Reset,
  input  logic           i_start,
  input  logic [KW-1:0]  i_k_size,
  input  logic [CHW-1:0] i_n_ch,
  input  logic           i_abort,
  input  logic           i_conf_ack,
  output logic           o_busy,
  output logic           o_conf_valid,
  output logic [BW-1:0]  o_conf_bus_idx,
  output logic [CHW-1:0] o_conf_ch,
  output logic           o_conf_slot_en,
  output logic [KW-1:0]  o_conf_col,
  output logic           o_conf_done,
  output logic           o_cfg_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StFill, StPad, StDone, StErr} state_e;

  state_e         r_state, w_state_d;
  logic [BW-1:0]  r_bus_cnt, w_bus_d;
  logic [KW-1:0]  r_win_cnt, w_win_d;
  logic [CHW-1:0] r_ch_cnt, w_ch_d;
  logic [KW-1:0]  r_k, w_k_d;
  logic [CHW-1:0] r_n, w_n_d;

  logic w_start_ok, w_bus_last, w_win_last, w_ch_last;

  assign w_start_ok = (i_k_size >= KW'(1)) && (i_k_size <= KW'(KSIZE_MAX)) &&
                      (i_n_ch >= CHW'(1)) && (i_n_ch <= CHW'(NUM_CH));
  assign w_bus_last = (r_bus_cnt == BW'(BUS_W - 1));
  assign w_win_last = (r_win_cnt == r_k - KW'(1));
  assign w_ch_last  = (r_ch_cnt == r_n - CHW'(1));

  always_ff @(posedge MUXDC_STATEMACHINE_Clk or negedge MUXDC_STATEMACHINE_Reset) begin
    if (!MUXDC_STATEMACHINE_Reset) begin
      r_state   <= StIdle;
      r_bus_cnt <= '0;
      r_win_cnt <= '0;
      r_ch_cnt  <= '0;
      r_k       <= '0;
      r_n       <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bus_cnt <= w_bus_d;
      r_win_cnt <= w_win_d;
      r_ch_cnt  <= w_ch_d;
      r_k       <= w_k_d;
      r_n       <= w_n_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_bus_d   = r_bus_cnt;
    w_win_d   = r_win_cnt;
    w_ch_d    = r_ch_cnt;
    w_k_d     = r_k;
    w_n_d     = r_n;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_start_ok) begin
            w_state_d = StLoad;
            w_k_d     = i_k_size;
            w_n_d     = i_n_ch;
          end else begin
            w_state_d = StErr;
          end
        end
      end
      StLoad: begin
        w_bus_d   = '0;
        w_win_d   = '0;
        w_ch_d    = '0;
        w_state_d = StFill;
      end
      StFill, StPad: begin
        // Bus terminal count wins over window terminal count (k == BUS_W never pads)
        if (w_bus_last) begin
          w_bus_d = '0;
          w_win_d = '0;
          if (w_ch_last) begin
            w_ch_d    = '0;
            w_state_d = StDone;
          end else begin
            w_ch_d    = r_ch_cnt + CHW'(1);
            w_state_d = StFill;
          end
        end else begin
          w_bus_d = r_bus_cnt + BW'(1);
          if (r_state == StFill) begin
            if (w_win_last) begin
              w_win_d   = '0;
              w_state_d = StPad;
            end else begin
              w_win_d = r_win_cnt + KW'(1);
            end
          end
        end
      end
      StDone: begin
        if (i_conf_ack) w_state_d = StIdle;
      end
      StErr:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (i_abort && (r_state != StIdle)) begin
      w_state_d = StIdle;
      w_bus_d   = '0;
      w_win_d   = '0;
      w_ch_d    = '0;
    end
  end

  // A rejected start never counts as activity, so busy stays low through StErr
  always_comb begin
    o_busy         = 1'b0;
    o_conf_valid   = 1'b0;
    o_conf_bus_idx = '0;
    o_conf_ch      = '0;
    o_conf_slot_en = 1'b0;
    o_conf_col     = '0;
    o_conf_done    = 1'b0;
    o_cfg_err      = 1'b0;
    unique case (r_state)
      StLoad: o_busy = 1'b1;
      StFill: begin
        o_busy         = 1'b1;
        o_conf_valid   = 1'b1;
        o_conf_bus_idx = r_bus_cnt;
        o_conf_ch      = r_ch_cnt;
        o_conf_slot_en = 1'b1;
        o_conf_col     = r_k - KW'(1) - r_win_cnt;
      end
      StPad: begin
        o_busy         = 1'b1;
        o_conf_valid   = 1'b1;
        o_conf_bus_idx = r_bus_cnt;
        o_conf_ch      = r_ch_cnt;
      end
      StDone: begin
        o_busy      = 1'b1;
        o_conf_done = 1'b1;
      end
      StErr:   o_cfg_err = 1'b1;
      default: ;
    endcase
  end

endmodule
